// File: rtl/dispatch_buffer.sv
// dispatch_buffer: in-order instruction buffer between decode and the RS/LSB issue ports,
// snooping the CDB so buffered and incoming operand tags resolve while waiting.
module dispatch_buffer #(
    parameter int DEPTH   = 4,
    parameter int CDB_NUM = 2,
    parameter int ROB_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [5:0]                 in_opnum,
    input  logic                       in_is_ls,
    input  logic [31:0]                in_imm,
    input  logic [31:0]                in_pc,
    input  logic [ROB_W-1:0]           in_rob_id,
    input  logic [ROB_W-1:0]           in_Q1,
    input  logic [ROB_W-1:0]           in_Q2,
    input  logic [31:0]                in_V1,
    input  logic [31:0]                in_V2,
    input  logic [CDB_NUM-1:0]         cdb_valid,
    input  logic [CDB_NUM*ROB_W-1:0]   cdb_rob_id,
    input  logic [CDB_NUM*32-1:0]      cdb_data,
    input  logic                       rollback,
    output logic                       rs_valid,
    input  logic                       rs_ready,
    output logic                       ls_valid,
    input  logic                       ls_ready,
    output logic [5:0]                 out_opnum,
    output logic [31:0]                out_imm,
    output logic [31:0]                out_pc,
    output logic [ROB_W-1:0]           out_rob_id,
    output logic [ROB_W-1:0]           out_Q1,
    output logic [ROB_W-1:0]           out_Q2,
    output logic [31:0]                out_V1,
    output logic [31:0]                out_V2,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [5:0]       opnum_q [DEPTH];
    logic             is_ls_q [DEPTH];
    logic [31:0]      imm_q   [DEPTH];
    logic [31:0]      pc_q    [DEPTH];
    logic [ROB_W-1:0] rob_q   [DEPTH];
    logic [ROB_W-1:0] q1_q    [DEPTH];
    logic [ROB_W-1:0] q2_q    [DEPTH];
    logic [31:0]      v1_q    [DEPTH];
    logic [31:0]      v2_q    [DEPTH];
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    cnt;
    logic             push, pop, has;
    logic [ROB_W-1:0] in_q1_s, in_q2_s;
    logic [31:0]      in_v1_s, in_v2_s;

    // Resolve one operand against the CDB; walking down makes the lowest channel win.
    function automatic logic [ROB_W+31:0] snoop(
        input logic [ROB_W-1:0]         q,
        input logic [31:0]              v,
        input logic [CDB_NUM-1:0]       cv,
        input logic [CDB_NUM*ROB_W-1:0] cid,
        input logic [CDB_NUM*32-1:0]    cd
    );
        logic [ROB_W+31:0] r;
        r = {q, v};
        for (int k = CDB_NUM - 1; k >= 0; k--)
            if (q != '0 && cv[k] && cid[k*ROB_W +: ROB_W] == q) r = {{ROB_W{1'b0}}, cd[k*32 +: 32]};
        return r;
    endfunction

    assign count      = cnt;
    assign has        = cnt != '0;
    assign in_ready   = (cnt < CW'(DEPTH)) && !rollback;
    assign rs_valid   = has && !is_ls_q[head] && !rollback;
    assign ls_valid   = has && is_ls_q[head] && !rollback;
    assign push       = in_valid && in_ready && rdy;
    assign pop        = rdy && ((rs_valid && rs_ready) || (ls_valid && ls_ready));
    assign out_opnum  = opnum_q[head];
    assign out_imm    = imm_q[head];
    assign out_pc     = pc_q[head];
    assign out_rob_id = rob_q[head];
    assign {out_Q1, out_V1}   = snoop(q1_q[head], v1_q[head], cdb_valid, cdb_rob_id, cdb_data);
    assign {out_Q2, out_V2}   = snoop(q2_q[head], v2_q[head], cdb_valid, cdb_rob_id, cdb_data);
    assign {in_q1_s, in_v1_s} = snoop(in_Q1, in_V1, cdb_valid, cdb_rob_id, cdb_data);
    assign {in_q2_s, in_v2_s} = snoop(in_Q2, in_V2, cdb_valid, cdb_rob_id, cdb_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (rollback) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (rdy) begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Payload needs no reset: nothing is visible until count says an entry is live.
    always_ff @(posedge clk) begin
        if (rdy && !rollback) begin
            for (int i = 0; i < DEPTH; i++) begin
                {q1_q[i], v1_q[i]} <= snoop(q1_q[i], v1_q[i], cdb_valid, cdb_rob_id, cdb_data);
                {q2_q[i], v2_q[i]} <= snoop(q2_q[i], v2_q[i], cdb_valid, cdb_rob_id, cdb_data);
            end
            if (push) begin
                opnum_q[tail] <= in_opnum;
                is_ls_q[tail] <= in_is_ls;
                imm_q[tail]   <= in_imm;
                pc_q[tail]    <= in_pc;
                rob_q[tail]   <= in_rob_id;
                q1_q[tail]    <= in_q1_s;
                v1_q[tail]    <= in_v1_s;
                q2_q[tail]    <= in_q2_s;
                v2_q[tail]    <= in_v2_s;
            end
        end
    end
endmodule

// File: doc/dispatch_buffer.md
DISPATCH_BUFFER -- requirements
Module: dispatch_buffer

Interface
REQ-001 SHALL have parameters: DEPTH, default 4, number of buffered instructions (power of 2, >=2); CDB_NUM, default 2, number of result broadcast channels; ROB_W, default 4, ROB id width; tag 0 means "value ready".
REQ-002 SHALL have ports as follows (one clock; reset is asynchronous and active-high).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 rdy  in  1  global enable; low freezes all state.
REQ-006 in_valid / in_ready  in / out  1 / 1  push handshake from the decode stage.
REQ-007 in_opnum, in_is_ls, in_imm, in_pc, in_rob_id  in  6, 1, 32, 32, ROB_W  decoded fields (in_is_ls=1: load/store).
REQ-008 in_Q1, in_Q2, in_V1, in_V2  in  ROB_W, ROB_W, 32, 32  operand tags and values from the register file/ROB.
REQ-009 cdb_valid, cdb_rob_id, cdb_data  in  CDB_NUM, CDB_NUM*ROB_W, CDB_NUM*32  result broadcasts.
REQ-010 rollback  in  1  flush request from ROB.
REQ-011 rs_valid / rs_ready, ls_valid / ls_ready  out / in  1 each  issue handshakes to RS and LSB.
REQ-012 out_opnum, out_imm, out_pc, out_rob_id, out_Q1, out_Q2, out_V1, out_V2  out  as inputs  head-entry payload, shared by both issue ports.
REQ-013 count  out  log2(DEPTH)+1  occupied entries.

Function
REQ-014 SHALL be an in-order circular FIFO of DEPTH entries; head/tail pointers SHALL wrap modulo DEPTH.
REQ-015 SHALL drive in_ready = (count < DEPTH) && !rollback, with no combinational path from rs_ready/ls_ready.
REQ-016 Push: in_valid && in_ready && rdy at the rising edge writes the entry at tail; tail++, count++.
REQ-017 Head steering: rs_valid = (count>0) && !head.is_ls && !rollback; ls_valid = (count>0) && head.is_ls && !rollback; at most one asserted.
REQ-018 Pop: (rs_valid && rs_ready) || (ls_valid && ls_ready) at the edge with rdy high; head++, count--; issue latency from push is >= 1 cycle.
REQ-019 Simultaneous push and pop: count unchanged, both SHALL take effect; when full, push is refused even if pop occurs that cycle.
REQ-020 Snoop: each cycle, every stored operand with Q!=0 matching cdb_rob_id[k] with cdb_valid[k] SHALL register Q<=0, V<=cdb_data[k].
REQ-021 Pushed operand matching a valid CDB channel in the push cycle SHALL be stored as Q=0 with that channel's data.
REQ-022 out_Q*/out_V* SHALL bypass same-cycle CDB matches combinationally (Q=0, V=cdb data) for the head entry.
REQ-023 Multiple channels matching one tag: lowest channel index wins.
REQ-024 Tag 0 SHALL never match a CDB channel.
REQ-025 rollback high at an edge SHALL empty the buffer (head=tail=0, count=0), discard any push or pop that cycle; takes precedence over rdy.
REQ-026 rdy low (no rollback): no push, pop or snoop updates; outputs hold.
REQ-027 Payload outputs with count==0 are don't-care; valids SHALL be 0.

Reset
REQ-028 rst high SHALL asynchronously clear head, tail and count to 0, force rs_valid=ls_valid=0, in_ready=1 after release; entry contents need not be reset.
REQ-029 rst asserted mid-operation SHALL discard all entries; first push after release lands in entry 0.

Verification
REQ-030 Push 4 ALU ops (rob ids 1..4), rs_ready=0 -> count=4, in_ready=0; raise rs_ready -> rob ids issue 1,2,3,4 on consecutive cycles, count returns to 0.
REQ-031 Full buffer, push and rs_ready pop same cycle -> pop occurs, push refused, count=3, in_ready=1 next cycle.
REQ-032 Entry with Q1=5 buffered; cdb_valid[1]=1, rob_id 5, data 0xDEADBEEF -> next cycle out_Q1=0, out_V1=0xDEADBEEF; same value bypassed on out_V1 in broadcast cycle.
REQ-033 Head is store (is_ls=1), ls_ready=0, rs_ready=1 -> rs_valid=0, head not issued until ls_ready=1; following ALU op waits behind it.
REQ-034 3 entries queued, rollback pulse with concurrent in_valid -> count=0, no issue, pushed entry dropped; next push issues normally.
REQ-035 Async rst mid-stream between clock edges -> count=0 and valids low immediately, before the next clk edge.
